// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, stall and flush control for the five-stage MIPS core.
// Forward selects and stall/flush outputs are combinational from the stage
// tags. A small FSM tracks the two multi-cycle events (multiply wait and
// D-cache load miss). Both events freeze the whole pipeline.
// Optional feature macro: HAZARD_PERF_EN enables the stall/miss perf counters.
// When the macro is undefined, the counter ports are tied to zero.
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       branchD,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             RegWriteE,
  input  logic [3:0]       WBSrcE,
  input  logic             MultStartE,
  input  logic             MultDoneE,
  input  logic             RegWriteM,
  input  logic [3:0]       WBSrcM,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             hitM,
  input  logic             RegWriteW,
  input  logic [REG_W-1:0] WriteRegW,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] miss_cycles
);

  localparam logic [1:0] S_RUN       = 2'b00;
  localparam logic [1:0] S_MULT_WAIT = 2'b01;
  localparam logic [1:0] S_MISS_WAIT = 2'b10;

  logic [1:0] state_q, state_d;
  logic       mult_busy_q, mult_busy_d;

  // A tag match never fires on register 0 (hardwired zero).
  function automatic logic tag_match(input logic [REG_W-1:0] wtag,
                                     input logic [REG_W-1:0] rtag);
    return (wtag != '0) && (wtag == rtag);
  endfunction

  // Only the load (bit1) and HI/LO (bit2) sources affect hazards; ALU and
  // PC+8 results are always forwardable.
  logic unused_wbsrc;
  assign unused_wbsrc = ^{WBSrcE[3], WBSrcE[0], WBSrcM[3:2], WBSrcM[0]};

  logic m_hits_rse, w_hits_rse, m_hits_rte, w_hits_rte;
  logic m_hits_rsd, m_hits_rtd, e_hits_d;
  logic lwstall, branchstall, missM, multwait, freeze;

  assign m_hits_rse  = RegWriteM & tag_match(WriteRegM, RsE);
  assign w_hits_rse  = RegWriteW & tag_match(WriteRegW, RsE);
  assign m_hits_rte  = RegWriteM & tag_match(WriteRegM, RtE);
  assign w_hits_rte  = RegWriteW & tag_match(WriteRegW, RtE);
  assign m_hits_rsd  = RegWriteM & tag_match(WriteRegM, RsD);
  assign m_hits_rtd  = RegWriteM & tag_match(WriteRegM, RtD);
  assign e_hits_d    = RegWriteE & (tag_match(WriteRegE, RsD) | tag_match(WriteRegE, RtD));

  // A load in Execute cannot be forwarded to Decode in time.
  assign lwstall     = WBSrcE[1] & e_hits_d;
  // The Decode branch comparator needs operands one stage earlier, so an
  // Execute producer or a Memory-stage load must still be waited out.
  assign branchstall = (branchD != 2'b00) &
                       (e_hits_d | (WBSrcM[1] & (m_hits_rsd | m_hits_rtd)));
  // Stores never miss-stall; only a register-writing load does.
  assign missM       = WBSrcM[1] & RegWriteM & ~hitM;
  // A HI/LO read must wait for an outstanding multiply; the done pulse
  // releases the freeze in the same cycle.
  assign multwait    = mult_busy_q & WBSrcE[2] & ~MultDoneE;
  assign freeze      = missM | multwait;

  // Multiply busy tracker; a new launch wins over a same-cycle completion.
  always_comb begin
    mult_busy_d = mult_busy_q;
    if (MultStartE)     mult_busy_d = 1'b1;
    else if (MultDoneE) mult_busy_d = 1'b0;
  end

  // State register and multiply-busy flag; reset aborts any wait at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      mult_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mult_busy_q <= mult_busy_d;
    end
  end

  // Next-state logic: a miss always takes precedence over a multiply wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (missM)         state_d = S_MISS_WAIT;
        else if (multwait) state_d = S_MULT_WAIT;
      end
      S_MISS_WAIT: begin
        if (hitM) state_d = S_RUN;
      end
      S_MULT_WAIT: begin
        if (missM)          state_d = S_MISS_WAIT;
        else if (MultDoneE) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Output logic: everything is held at zero while reset is asserted.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    stallW    = 1'b0;
    flushE    = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (!rst) begin
      forwardAD = m_hits_rsd;
      forwardBD = m_hits_rtd;
      if (m_hits_rse)      forwardAE = 2'b10;
      else if (w_hits_rse) forwardAE = 2'b01;
      if (m_hits_rte)      forwardBE = 2'b10;
      else if (w_hits_rte) forwardBE = 2'b01;
      if (freeze) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        stallW = 1'b1;
      end else if (lwstall | branchstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, miss_cnt_q;
  logic             any_stall, miss_cycle;

  assign any_stall  = stallF | stallD | stallE | stallM | stallW;
  assign miss_cycle = (state_q == S_MISS_WAIT) | missM;

  // Saturating perf counters for stall cycles and miss-wait cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      if (any_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (miss_cycle && (miss_cnt_q != '1)) miss_cnt_q  <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign miss_cycles  = miss_cnt_q;
`else
  assign stall_cycles = '0;
  assign miss_cycles  = '0;
`endif

endmodule
